cam_search_engine: RTL and testbench

- Parametrised ternary CAM with an encoded write/invalidate port, per-entry stored care masks and valid bits.
- Pipelined search path with valid/ready handshake on request and response.
- Response carries raw match vector, hit, multi-hit and priority-encoded lowest matching index.
- Successor to the row-array CAM; used as lookup engine behind the lab datapath.

---
 rtl/cam_search_engine_pkg.sv | 28 ++
 rtl/cam_search_engine_priority.sv | 24 ++
 rtl/cam_search_engine.sv | 115 +++++++++++
 tb/tb_cam_search_engine.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_search_engine_pkg.sv
// Shared constants, maintenance-op encoding and index-width helper for the
// ternary CAM search engine.
package cam_search_engine_pkg;

  localparam int CAM_WIDTH_DEF = 8;
  localparam int CAM_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    MNT_NONE,
    MNT_WRITE,
    MNT_INV,
    MNT_FLUSH
  } maint_op_e;

  function automatic int cam_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // flush dominates invalidate, which dominates write
  function automatic maint_op_e maint_decode(input logic flush, input logic inv_en,
                                             input logic wr_en);
    if (flush)       return MNT_FLUSH;
    else if (inv_en) return MNT_INV;
    else if (wr_en)  return MNT_WRITE;
    return MNT_NONE;
  endfunction

endpackage

// File: rtl/cam_search_engine_priority.sv
// Stage-2 reduction of a match vector: any-hit, multi-hit and lowest set index.
module cam_priority_encoder
  import cam_search_engine_pkg::*;
#(
  parameter int CAM_DEPTH = CAM_DEPTH_DEF,
  localparam int ADDR_W = cam_addr_w(CAM_DEPTH)
) (
  input  logic [CAM_DEPTH-1:0] match_vec,
  output logic                 hit,
  output logic                 multi_hit,
  output logic [ADDR_W-1:0]    addr
);

  always_comb begin
    hit       = |match_vec;
    // clearing the lowest set bit leaves something only if two or more were set
    multi_hit = |(match_vec & (match_vec - CAM_DEPTH'(1)));
    addr      = '0;
    for (int unsigned i = CAM_DEPTH; i > 0; i--) begin
      if (match_vec[i-1]) addr = ADDR_W'(i - 1);
    end
  end

endmodule

// File: rtl/cam_search_engine.sv
// Ternary CAM with encoded write/invalidate port and a two-stage search
// pipeline (compare, then reduce) behind valid/ready handshakes.
module cam_search_engine
  import cam_search_engine_pkg::*;
#(
  parameter int CAM_WIDTH = CAM_WIDTH_DEF,
  parameter int CAM_DEPTH = CAM_DEPTH_DEF,
  localparam int ADDR_W = cam_addr_w(CAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 inv_en,
  input  logic                 flush,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [CAM_WIDTH-1:0] wr_data,
  input  logic [CAM_WIDTH-1:0] wr_care_mask,
  input  logic                 srch_valid,
  output logic                 srch_ready,
  input  logic [CAM_WIDTH-1:0] search_word,
  input  logic [CAM_WIDTH-1:0] dont_care_mask,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CAM_DEPTH-1:0] rsp_match_vec,
  output logic                 rsp_hit,
  output logic                 rsp_multi_hit,
  output logic [ADDR_W-1:0]    rsp_addr
);

  maint_op_e            mop;
  logic [CAM_DEPTH-1:0] match_now;
  logic [CAM_DEPTH-1:0] s1_vec;
  logic                 s1_valid;
  logic                 stall;
  logic                 accept;
  logic                 pe_hit;
  logic                 pe_multi_hit;
  logic [ADDR_W-1:0]    pe_addr;

  always_comb begin
    mop = maint_decode(flush, inv_en, wr_en);
  end

  // Out-of-range wr_addr never equals any entry index, so it is ignored.
  for (genvar i = 0; i < CAM_DEPTH; i++) begin : g_entry
    logic                 sel;
    logic                 valid_q;
    logic [CAM_WIDTH-1:0] data_q;
    logic [CAM_WIDTH-1:0] care_q;

    always_comb begin
      sel = (wr_addr == ADDR_W'(i));
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        care_q  <= '0;
      end else begin
        case (mop)
          MNT_FLUSH: valid_q <= 1'b0;
          MNT_INV:   if (sel) valid_q <= 1'b0;
          MNT_WRITE: if (sel) begin
            valid_q <= 1'b1;
            data_q  <= wr_data;
            care_q  <= wr_care_mask;
          end
          default: ;
        endcase
      end
    end

    always_comb begin
      match_now[i] = valid_q & ~|((data_q ^ search_word) & care_q & ~dont_care_mask);
    end
  end

  always_comb begin
    stall      = rsp_valid & ~rsp_ready;
    srch_ready = ~stall;
    accept     = srch_valid & srch_ready;
  end

  cam_priority_encoder #(
    .CAM_DEPTH (CAM_DEPTH)
  ) u_pe (
    .match_vec (s1_vec),
    .hit       (pe_hit),
    .multi_hit (pe_multi_hit),
    .addr      (pe_addr)
  );

  // S1 vector is zeroed on bubbles so an idle response slot reads all-zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid      <= 1'b0;
      s1_vec        <= '0;
      rsp_valid     <= 1'b0;
      rsp_match_vec <= '0;
      rsp_hit       <= 1'b0;
      rsp_multi_hit <= 1'b0;
      rsp_addr      <= '0;
    end else if (!stall) begin
      s1_valid      <= accept;
      s1_vec        <= accept ? match_now : '0;
      rsp_valid     <= s1_valid;
      rsp_match_vec <= s1_vec;
      rsp_hit       <= pe_hit;
      rsp_multi_hit <= pe_multi_hit;
      rsp_addr      <= pe_addr;
    end
  end

endmodule

// File: tb/tb_cam_search_engine.sv
// Directed bench for cam_search_engine: queue-based reference model checked
// every cycle, plus literal expectations for the hand-worked scenarios.
module tb_cam_search_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, inv_en, flush;
  logic [2:0] wr_addr;
  logic [7:0] wr_data, wr_care_mask;
  logic       srch_valid, srch_ready;
  logic [7:0] search_word, dont_care_mask;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_match_vec;
  logic       rsp_hit, rsp_multi_hit;
  logic [2:0] rsp_addr;

  int n_checks = 0;
  int n_fail   = 0;

  cam_search_engine #(
    .CAM_WIDTH (8),
    .CAM_DEPTH (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .inv_en         (inv_en),
    .flush          (flush),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_care_mask   (wr_care_mask),
    .srch_valid     (srch_valid),
    .srch_ready     (srch_ready),
    .search_word    (search_word),
    .dont_care_mask (dont_care_mask),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_match_vec  (rsp_match_vec),
    .rsp_hit        (rsp_hit),
    .rsp_multi_hit  (rsp_multi_hit),
    .rsp_addr       (rsp_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] vec;
    int         acc;
  } item_t;

  logic       m_valid [8];
  logic [7:0] m_data  [8];
  logic [7:0] m_care  [8];
  item_t      q[$];
  item_t      cur;
  logic       pv = 1'b0;
  logic       started = 1'b0;
  int         cyc = 0;

  function automatic logic [7:0] mdl_match(input logic [7:0] key, input logic [7:0] dcm);
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++)
      if (m_valid[i] && (((m_data[i] ^ key) & m_care[i] & ~dcm) == 8'h00)) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [2:0] lowest(input logic [7:0] v);
    logic [2:0] a = '0;
    for (int i = 7; i >= 0; i--) if (v[i]) a = 3'(i);
    return a;
  endfunction

  // Inputs change only just after posedge, so at negedge they hold the values
  // the next edge will see; outputs hold what the previous edge produced.
  always @(negedge clk) begin
    logic rdy;
    if (started) begin
      chk("mdl_rsp_valid", 32'(rsp_valid), 32'(pv));
      chk("mdl_srch_ready", 32'(srch_ready), 32'(!(pv && !rsp_ready)));
      if (pv) begin
        chk("mdl_match_vec", 32'(rsp_match_vec), 32'(cur.vec));
        chk("mdl_hit", 32'(rsp_hit), 32'(cur.vec != 8'h00));
        chk("mdl_multi_hit", 32'(rsp_multi_hit), 32'($countones(cur.vec) >= 2));
        chk("mdl_addr", 32'(rsp_addr), 32'(lowest(cur.vec)));
      end
    end
    if (rst === 1'b0) begin
      started = 1'b1;
      for (int i = 0; i < 8; i++) begin
        m_valid[i] = 1'b0; m_data[i] = '0; m_care[i] = '0;
      end
      q.delete();
      pv = 1'b0;
    end else if (started) begin
      rdy = !(pv && !rsp_ready);
      if (pv && rsp_ready) pv = 1'b0;
      if (srch_valid && rdy) q.push_back('{vec: mdl_match(search_word, dont_care_mask), acc: cyc});
      if (flush) begin
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      end else if (inv_en) begin
        m_valid[wr_addr] = 1'b0;
      end else if (wr_en) begin
        m_valid[wr_addr] = 1'b1;
        m_data[wr_addr]  = wr_data;
        m_care[wr_addr]  = wr_care_mask;
      end
      if (!pv && q.size() > 0 && q[0].acc + 1 <= cyc) begin
        cur = q.pop_front();
        pv  = 1'b1;
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [2:0] a, input logic [7:0] d, input logic [7:0] c);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_care_mask = c;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic search(input logic [7:0] key, input logic [7:0] dcm);
    logic r = 1'b0;
    srch_valid = 1'b1; search_word = key; dont_care_mask = dcm;
    for (int k = 0; k < 50 && !r; k++) begin
      @(negedge clk);
      r = srch_ready;
      tick();
    end
    srch_valid = 1'b0;
    if (!r) chk("search_accept_timeout", 32'(r), 32'd1);
  endtask

  task automatic expect_rsp(input string nm, input logic [7:0] vec, input logic hit,
                            input logic multi, input logic [2:0] addr, output int lat);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (rsp_valid) break;
      lat++;
    end
    chk({nm, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({nm, "_vec"}, 32'(rsp_match_vec), 32'(vec));
    chk({nm, "_hit"}, 32'(rsp_hit), 32'(hit));
    chk({nm, "_multi"}, 32'(rsp_multi_hit), 32'(multi));
    chk({nm, "_addr"}, 32'(rsp_addr), 32'(addr));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b0; wr_en = 1'b0; inv_en = 1'b0; flush = 1'b0;
    wr_addr = '0; wr_data = '0; wr_care_mask = '0;
    srch_valid = 1'b0; search_word = '0; dont_care_mask = '0; rsp_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_srch_ready", 32'(srch_ready), 32'd1);
    chk("reset_match_vec", 32'(rsp_match_vec), 32'd0);
    chk("reset_addr", 32'(rsp_addr), 32'd0);
    tick();

    // exact single-entry match, and its latency in negedge samples
    write(3'd3, 8'hA5, 8'hFF);
    search(8'hA5, 8'h00);
    expect_rsp("t1", 8'h08, 1'b1, 1'b0, 3'd3, lat);
    chk("t1_latency", 32'(lat), 32'd1);

    // nibble-masked entries, multi-hit, then invalidate the lower one
    write(3'd2, 8'h30, 8'hF0);
    write(3'd5, 8'h30, 8'hF0);
    search(8'h3C, 8'h00);
    expect_rsp("t2a", 8'h24, 1'b1, 1'b1, 3'd2, lat);
    inv_en = 1'b1; wr_addr = 3'd2; tick(); inv_en = 1'b0;
    search(8'h3C, 8'h00);
    expect_rsp("t2b", 8'h20, 1'b1, 1'b0, 3'd5, lat);

    // write and search on the same edge miss; next-cycle search hits
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h11; wr_care_mask = 8'hFF;
    search(8'h11, 8'h00);
    wr_en = 1'b0;
    search(8'h11, 8'h00);
    expect_rsp("t3a", 8'h00, 1'b0, 1'b0, 3'd0, lat);
    expect_rsp("t3b", 8'h02, 1'b1, 1'b0, 3'd1, lat);

    // three back-to-back searches against a four-cycle response stall
    rsp_ready = 1'b0;
    fork
      begin
        search(8'hA5, 8'h00);
        search(8'h3C, 8'h00);
        search(8'h11, 8'h00);
      end
      begin
        repeat (2) tick();
        @(negedge clk);
        chk("t4_stall_ready", 32'(srch_ready), 32'd0);
        chk("t4_stall_valid", 32'(rsp_valid), 32'd1);
        chk("t4_stall_addr", 32'(rsp_addr), 32'd3);
        tick();
        @(negedge clk);
        chk("t4_hold_vec", 32'(rsp_match_vec), 32'h08);
        tick();
        rsp_ready = 1'b1;
      end
    join
    expect_rsp("t4b", 8'h20, 1'b1, 1'b0, 3'd5, lat);
    expect_rsp("t4c", 8'h02, 1'b1, 1'b0, 3'd1, lat);
    @(negedge clk);
    chk("t4_drained", 32'(rsp_valid), 32'd0);
    tick();

    // full-mask search sees every valid entry; inv beats wr on the same entry
    search(8'h00, 8'hFF);
    expect_rsp("t5a", 8'h2A, 1'b1, 1'b1, 3'd1, lat);
    inv_en = 1'b1; wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'h66; wr_care_mask = 8'hFF;
    tick();
    inv_en = 1'b0; wr_en = 1'b0;
    search(8'h66, 8'h00);
    expect_rsp("t5b", 8'h00, 1'b0, 1'b0, 3'd0, lat);
    flush = 1'b1; inv_en = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
    tick();
    flush = 1'b0; inv_en = 1'b0; wr_en = 1'b0;
    search(8'h00, 8'hFF);
    expect_rsp("t5c", 8'h00, 1'b0, 1'b0, 3'd0, lat);

    // reset with two searches in flight
    write(3'd4, 8'h44, 8'hFF);
    search(8'h44, 8'h00);
    search(8'h44, 8'h00);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_match_vec", 32'(rsp_match_vec), 32'd0);
    chk("t6_hit", 32'(rsp_hit), 32'd0);
    chk("t6_addr", 32'(rsp_addr), 32'd0);
    chk("t6_srch_ready", 32'(srch_ready), 32'd1);
    tick();
    @(negedge clk);
    chk("t6_no_late_rsp", 32'(rsp_valid), 32'd0);
    tick();
    search(8'h00, 8'hFF);
    expect_rsp("t6_empty", 8'h00, 1'b0, 1'b0, 3'd0, lat);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
